// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared state encoding and constants for the SPI command sequencer
package spi_cmd_pkg;
  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    WR_BUS,
    RD_BUS,
    RD_WAIT,
    ABORT
  } state_e;
  localparam int CMD_RD_BIT = 7;
  localparam logic [7:0] ABORT_BYTE = 8'hFF;
endpackage

// File: rtl/spi_cmd_sync.sv
// spi_cmd_sync: 2-flop ssel_n synchroniser with frame start/end strobes
module spi_cmd_sync (
  input  logic clk,
  input  logic rst,
  input  logic ssel_n_i,
  output logic sel_o,
  output logic rise_o,
  output logic fall_o
);
  logic s1_q, s2_q, s3_q;
  // Reset to "selected" so a frame already in progress at reset is not mistaken for a new one
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= ~ssel_n_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end
  assign sel_o  = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;
endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: turns SPI command frames into single-beat register-bus transactions.
// Define SPI_CMD_AUTOINC_EN for burst address auto-increment; otherwise the address is held per frame.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int AW = 7,
  parameter int TIMEOUT = 15,
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ssel_n,
  input  logic          byte_received,
  input  logic [7:0]    byte_data_received,
  output logic [7:0]    byte_send,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [7:0]    bus_wdata,
  input  logic [7:0]    bus_rdata,
  input  logic          bus_ack,
  output logic          busy,
  output logic          err
);
  localparam int CW = $clog2(TIMEOUT + 1);
`ifdef SPI_CMD_AUTOINC_EN
  localparam logic [AW-1:0] INC = AW'(1);
`else
  localparam logic [AW-1:0] INC = '0;
`endif
  state_e        state_q;
  logic [7:0]    byte_send_q, bus_wdata_q;
  logic          bus_req_q, bus_we_q, err_q;
  logic [AW-1:0] bus_addr_q;
  logic [CW-1:0] cnt_q;
  logic          sel, sel_rise, sel_fall;
  spi_cmd_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .ssel_n_i (ssel_n),
    .sel_o    (sel),
    .rise_o   (sel_rise),
    .fall_o   (sel_fall)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_send_q <= IDLE_BYTE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else if (sel_fall) begin
      state_q   <= IDLE;
      bus_req_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (sel_rise) begin
          state_q     <= CMD;
          err_q       <= 1'b0;
          byte_send_q <= IDLE_BYTE;
        end
        CMD: if (byte_received) begin
          bus_addr_q <= AW'(byte_data_received[6:0]);
          if (byte_data_received[CMD_RD_BIT]) begin
            state_q   <= RD_BUS;
            bus_req_q <= 1'b1;
            bus_we_q  <= 1'b0;
            cnt_q     <= '0;
          end else begin
            state_q <= WR_DATA;
          end
        end
        WR_DATA: if (byte_received) begin
          state_q     <= WR_BUS;
          bus_wdata_q <= byte_data_received;
          bus_req_q   <= 1'b1;
          bus_we_q    <= 1'b1;
          cnt_q       <= '0;
        end
        WR_BUS, RD_BUS: begin
          // A byte arriving while the bus is still busy is an SPI overrun
          if (byte_received) err_q <= 1'b1;
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            if (state_q == WR_BUS) begin
              state_q    <= WR_DATA;
              bus_addr_q <= bus_addr_q + INC;
            end else begin
              state_q     <= RD_WAIT;
              byte_send_q <= bus_rdata;
            end
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q     <= ABORT;
            bus_req_q   <= 1'b0;
            err_q       <= 1'b1;
            byte_send_q <= ABORT_BYTE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RD_WAIT: if (byte_received) begin
          state_q    <= RD_BUS;
          bus_addr_q <= bus_addr_q + INC;
          bus_req_q  <= 1'b1;
          bus_we_q   <= 1'b0;
          cnt_q      <= '0;
        end
        default: ;
      endcase
    end
  end
  assign byte_send = byte_send_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign err       = err_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: directed self-checking bench for spi_cmd_ctrl with a register-file responder
module tb_spi_cmd_ctrl;
`ifdef SPI_CMD_AUTOINC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif
  logic       clk = 0, rst = 1, ssel_n = 1, byte_received = 0, bus_ack = 0;
  logic [7:0] byte_data_received = 0, bus_rdata = 0, byte_send, bus_wdata;
  logic [6:0] bus_addr;
  logic       bus_req, bus_we, busy, err;
  logic [7:0] regs [128];
  logic [15:0] wlog [$];
  int  vectors = 0, miscompares = 0;
  int  ack_delay = 3, wait_cnt = 0;
  logic ack_en = 1, force_ack = 0;

  spi_cmd_ctrl dut (
    .clk(clk), .rst(rst), .ssel_n(ssel_n), .byte_received(byte_received),
    .byte_data_received(byte_data_received), .byte_send(byte_send),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      tick();
      bus_ack = 0;
      if (force_ack) begin
        bus_ack = 1;
        force_ack = 0;
      end else if (bus_req && ack_en) begin
        if (wait_cnt == ack_delay) begin
          bus_ack = 1;
          wait_cnt = 0;
          if (bus_we) begin
            wlog.push_back({1'b0, bus_addr, bus_wdata});
            regs[bus_addr] = bus_wdata;
          end else bus_rdata = regs[bus_addr];
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    byte_data_received = b;
    byte_received = 1;
    tick();
    byte_received = 0;
  endtask

  task automatic start_frame();
    ssel_n = 0;
    repeat (4) tick();
  endtask

  task automatic end_frame();
    ssel_n = 1;
    repeat (4) tick();
  endtask

  task automatic wait_bus(input string name);
    for (int i = 0; i < 40 && bus_req; i++) tick();
    vectors++;
    if (bus_req !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: bus_req still %b after 40 cycles, wanted 0", name, bus_req);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    vectors += 7;
    if (byte_send !== 8'h00) begin miscompares++; $display("FAIL reset byte_send got %h want 00", byte_send); end
    if (bus_req !== 1'b0) begin miscompares++; $display("FAIL reset bus_req got %b want 0", bus_req); end
    if (bus_we !== 1'b0) begin miscompares++; $display("FAIL reset bus_we got %b want 0", bus_we); end
    if (bus_addr !== 7'h00) begin miscompares++; $display("FAIL reset bus_addr got %h want 00", bus_addr); end
    if (bus_wdata !== 8'h00) begin miscompares++; $display("FAIL reset bus_wdata got %h want 00", bus_wdata); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b want 0", busy); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL reset err got %b want 0", err); end
    rst = 0;
    repeat (4) tick();
  endtask

  task automatic test_write_burst();
    ack_delay = 3;
    wlog.delete();
    start_frame();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL wr busy got %b want 1", busy); end
    send_byte(8'h05);
    tick();
    send_byte(8'hA1);
    vectors += 4;
    if (bus_req !== 1'b1) begin miscompares++; $display("FAIL wr bus_req got %b want 1", bus_req); end
    if (bus_we !== 1'b1) begin miscompares++; $display("FAIL wr bus_we got %b want 1", bus_we); end
    if (bus_addr !== 7'h05) begin miscompares++; $display("FAIL wr bus_addr got %h want 05", bus_addr); end
    if (bus_wdata !== 8'hA1) begin miscompares++; $display("FAIL wr bus_wdata got %h want A1", bus_wdata); end
    wait_bus("wr first");
    send_byte(8'hB2);
    wait_bus("wr second");
    vectors += 4;
    if (wlog.size() !== 2) begin miscompares++; $display("FAIL wr count got %0d want 2", wlog.size()); end
    else begin
      if (wlog[0] !== 16'h05A1) begin miscompares++; $display("FAIL wr beat0 got %h want 05A1", wlog[0]); end
      if (wlog[1] !== {8'(5 + INC), 8'hB2}) begin miscompares++; $display("FAIL wr beat1 got %h want %h", wlog[1], {8'(5 + INC), 8'hB2}); end
    end
    if (err !== 1'b0) begin miscompares++; $display("FAIL wr err got %b want 0", err); end
    end_frame();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL wr end busy got %b want 0", busy); end
  endtask

  task automatic test_read_burst();
    regs[7'h10] = 8'h3C;
    regs[7'h11] = 8'h4D;
    regs[7'h12] = 8'h5E;
    start_frame();
    send_byte(8'h90);
    vectors += 3;
    if (bus_req !== 1'b1) begin miscompares++; $display("FAIL rd bus_req got %b want 1", bus_req); end
    if (bus_we !== 1'b0) begin miscompares++; $display("FAIL rd bus_we got %b want 0", bus_we); end
    if (bus_addr !== 7'h10) begin miscompares++; $display("FAIL rd bus_addr got %h want 10", bus_addr); end
    wait_bus("rd first");
    vectors++;
    if (byte_send !== 8'h3C) begin miscompares++; $display("FAIL rd byte0 got %h want 3C", byte_send); end
    send_byte(8'h00);
    vectors += 2;
    if (bus_req !== 1'b1) begin miscompares++; $display("FAIL rd prefetch1 req got %b want 1", bus_req); end
    if (bus_addr !== 7'(16 + INC)) begin miscompares++; $display("FAIL rd prefetch1 addr got %h want %h", bus_addr, 7'(16 + INC)); end
    wait_bus("rd second");
    vectors++;
    if (byte_send !== (INC != 0 ? 8'h4D : 8'h3C)) begin miscompares++; $display("FAIL rd byte1 got %h", byte_send); end
    send_byte(8'h00);
    vectors++;
    if (bus_addr !== 7'(16 + 2 * INC)) begin miscompares++; $display("FAIL rd prefetch2 addr got %h want %h", bus_addr, 7'(16 + 2 * INC)); end
    wait_bus("rd third");
    end_frame();
  endtask

  task automatic test_timeout();
    int n = 0;
    ack_en = 0;
    start_frame();
    send_byte(8'h80);
    for (int i = 0; i < 40 && bus_req; i++) begin
      n++;
      tick();
    end
    vectors += 3;
    if (n !== 15) begin miscompares++; $display("FAIL timeout req cycles got %0d want 15", n); end
    if (err !== 1'b1) begin miscompares++; $display("FAIL timeout err got %b want 1", err); end
    if (byte_send !== 8'hFF) begin miscompares++; $display("FAIL timeout byte_send got %h want FF", byte_send); end
    ack_en = 1;
    send_byte(8'h00);
    send_byte(8'h12);
    tick();
    vectors += 3;
    if (bus_req !== 1'b0) begin miscompares++; $display("FAIL abort bus_req got %b want 0", bus_req); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL abort busy got %b want 1", busy); end
    if (byte_send !== 8'hFF) begin miscompares++; $display("FAIL abort byte_send got %h want FF", byte_send); end
    end_frame();
    vectors += 2;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort end busy got %b want 0", busy); end
    if (err !== 1'b1) begin miscompares++; $display("FAIL err sticky got %b want 1", err); end
  endtask

  task automatic test_overrun();
    ack_delay = 5;
    wlog.delete();
    start_frame();
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL new frame err got %b want 0", err); end
    send_byte(8'h20);
    send_byte(8'h11);
    send_byte(8'h99);
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL overrun err got %b want 1", err); end
    wait_bus("overrun");
    vectors += 2;
    if (wlog.size() !== 1) begin miscompares++; $display("FAIL overrun count got %0d want 1", wlog.size()); end
    else if (wlog[0] !== 16'h2011) begin miscompares++; $display("FAIL overrun beat got %h want 2011", wlog[0]); end
    if (bus_req !== 1'b0) begin miscompares++; $display("FAIL overrun req got %b want 0", bus_req); end
    end_frame();
    ack_delay = 3;
  endtask

  task automatic test_abort_sel();
    ack_en = 0;
    wlog.delete();
    start_frame();
    send_byte(8'h03);
    send_byte(8'h55);
    vectors++;
    if (bus_req !== 1'b1) begin miscompares++; $display("FAIL sel-abort req before got %b want 1", bus_req); end
    ssel_n = 1;
    repeat (3) tick();
    vectors += 2;
    if (bus_req !== 1'b0) begin miscompares++; $display("FAIL sel-abort req got %b want 0", bus_req); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL sel-abort busy got %b want 0", busy); end
    force_ack = 1;
    repeat (3) tick();
    vectors += 4;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL late ack busy got %b want 0", busy); end
    if (bus_req !== 1'b0) begin miscompares++; $display("FAIL late ack req got %b want 0", bus_req); end
    if (bus_addr !== 7'h03) begin miscompares++; $display("FAIL late ack addr got %h want 03", bus_addr); end
    if (wlog.size() !== 0) begin miscompares++; $display("FAIL late ack writes got %0d want 0", wlog.size()); end
    ack_en = 1;
  endtask

  task automatic test_wrap();
    wlog.delete();
    start_frame();
    send_byte(8'h7F);
    send_byte(8'h01);
    wait_bus("wrap first");
    send_byte(8'h02);
    wait_bus("wrap second");
    vectors += 3;
    if (wlog.size() !== 2) begin miscompares++; $display("FAIL wrap count got %0d want 2", wlog.size()); end
    else begin
      if (wlog[0] !== 16'h7F01) begin miscompares++; $display("FAIL wrap beat0 got %h want 7F01", wlog[0]); end
      if (wlog[1] !== (INC != 0 ? 16'h0002 : 16'h7F02)) begin miscompares++; $display("FAIL wrap beat1 got %h", wlog[1]); end
    end
    end_frame();
  endtask

  task automatic test_reset_mid();
    start_frame();
    send_byte(8'h90);
    wait_bus("mid read");
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL mid busy got %b want 1", busy); end
    rst = 1;
    tick();
    vectors += 5;
    if (byte_send !== 8'h00) begin miscompares++; $display("FAIL mid rst byte_send got %h want 00", byte_send); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL mid rst busy got %b want 0", busy); end
    if (bus_req !== 1'b0) begin miscompares++; $display("FAIL mid rst req got %b want 0", bus_req); end
    if (bus_addr !== 7'h00) begin miscompares++; $display("FAIL mid rst addr got %h want 00", bus_addr); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL mid rst err got %b want 0", err); end
    rst = 0;
    repeat (4) tick();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL held sel busy got %b want 0", busy); end
    end_frame();
    start_frame();
    send_byte(8'h91);
    vectors += 2;
    if (bus_req !== 1'b1) begin miscompares++; $display("FAIL post-rst req got %b want 1", bus_req); end
    if (bus_addr !== 7'h11) begin miscompares++; $display("FAIL post-rst addr got %h want 11", bus_addr); end
    wait_bus("post-rst read");
    vectors++;
    if (byte_send !== 8'h4D) begin miscompares++; $display("FAIL post-rst byte got %h want 4D", byte_send); end
    end_frame();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_timeout();
    test_overrun();
    test_abort_sel();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
Command sequencer that sits behind the SPI slave byte engine in the CPLD and turns SPI frames into register-bus transactions.
- Byte 0 of each frame is a command byte: bit7 = 1 for read, 0 for write; bits6:0 = start address.
- Following bytes are write data, or dummy bytes that clock out read data.
- The block issues single-beat req/ack transactions to the CPLD register file and keeps the SPI slave's byte_send loaded one byte ahead.

Parameters:
AW, 7, register-bus address width (fixed ≤7; command byte carries 7 address bits, zero-extended/truncated to AW)
TIMEOUT, 15, max clk cycles to wait for bus_ack before abort; counter width = clog2(TIMEOUT+1)
IDLE_BYTE, 8'h00, value placed on byte_send when no read data is valid

Ports:
clk  in  1  system clock, same domain as the SPI slave
rst  in  1  synchronous reset, active-high
ssel_n  in  1  raw SPI chip select, active low; synchronised internally with 2 flops
byte_received  in  1  single-cycle strobe from the SPI slave: a byte is complete
byte_data_received  in  8  received byte, valid while byte_received=1
byte_send  out  8  next byte for the SPI slave to shift out
bus_req  out  1  register-bus request, held until bus_ack
bus_we  out  1  1=write, 0=read; stable while bus_req=1
bus_addr  out  AW  transaction address
bus_wdata  out  8  write data
bus_rdata  in  8  read data, valid with bus_ack on reads
bus_ack  in  1  single-cycle completion from the register file
busy  out  1  1 while the state is not IDLE
err  out  1  sticky timeout flag; cleared by rst or by the start of a new frame

Behaviour:
Reset values:
- State IDLE; byte_send=IDLE_BYTE; bus_req=0; bus_we=0; bus_addr=0; bus_wdata=0; busy=0; err=0.

Frame tracking:
- sel = ~ssel_n after 2-flop sync.
- Deassertion of sel forces IDLE from any state on the next clk. Any bus_req in flight is dropped, and the late bus_ack is ignored.

States:
- IDLE: on sel rising, go to CMD, clear err, byte_send=IDLE_BYTE.
- CMD: on byte_received, latch addr=data[6:0].
  - Read (data[7]=1): go to RD_BUS with bus_req=1, bus_we=0.
  - Write: go to WR_DATA.
- WR_DATA: on byte_received, set bus_wdata=data, bus_req=1, bus_we=1, go to WR_BUS.
- WR_BUS: on bus_ack, drop bus_req, addr+=1 (autoinc), go to WR_DATA.
- RD_BUS: on bus_ack, byte_send=bus_rdata, drop bus_req, go to RD_WAIT.
- RD_WAIT: on byte_received (byte_send consumed), addr+=1 (autoinc), go to RD_BUS (prefetch).
- Timeout:
  - In WR_BUS/RD_BUS, the counter runs from entry. Reaching TIMEOUT without ack drops bus_req, sets err=1, byte_send=8'hFF, and enters ABORT.
  - ABORT: ignore bytes until sel falls.

Timing:
- Read latency budget: the bus read must complete before the next SCK falling edge after byte_received. The system requires ≥(TIMEOUT+2) clk per half SCK period.
- bus_req asserts the cycle after the triggering byte_received or state entry.
- Address wrap: addr+1 wraps modulo 2^AW.

Simultaneous events:
- sel fall has priority over byte_received, bus_ack and timeout.
- byte_received in RD_BUS/WR_BUS (SPI overrun) is ignored and sets err.

Reset mid-frame returns to IDLE. A new frame is not recognised until sel is seen low then high.

Optional Feature:
SPI_CMD_AUTOINC_EN
- Defined: address increments after every data byte as described, allowing burst access.
- Undefined: address is held at the command-byte value for the whole frame, so repeated writes/reads hit one register (FIFO-port style).

Decomposition:
- Package spi_cmd_pkg holds:
  - state enum (IDLE, CMD, WR_DATA, WR_BUS, RD_BUS, RD_WAIT, ABORT)
  - CMD_RD_BIT=7
  - ABORT_BYTE=8'hFF
- One sub-module is natural: spi_cmd_sync, the 2-flop ssel_n synchroniser with rising/falling edge strobes.
- The timeout counter stays inline.

Test Plan:
- Write burst: frame cmd 8'h05 then 8'hA1, 8'hB2, ack after 3 clk → bus writes addr 5=A1, addr 6=B2; bus_we=1; err=0.
- Read burst: cmd 8'h90, regs[0x10]=8'h3C, regs[0x11]=8'h4D → byte_send=3C after first ack; 4D after next byte_received; prefetch of 0x12 issued.
- Timeout: read cmd 8'h80, bus_ack never asserted → bus_req drops after 15 cycles; err=1; byte_send=FF; following bytes produce no bus activity.
- Abort by select: ssel_n high while in WR_BUS → IDLE next clk; bus_req=0; a late ack has no effect; busy=0.
- Wrap: with AW=7, write cmd 8'h7F and two data bytes → addresses 7F then 00; with SPI_CMD_AUTOINC_EN undefined, both go to 7F.
- Reset mid-frame: rst pulse during RD_WAIT → all outputs return to reset values; the next frame's command is decoded normally.
